mmio_bus_bridge: RTL
====================

Name: mmio_bus_bridge

Overview:
- Sits directly downstream of the 16-bit CPU memory port (adr, memOut, memwrite, memdata). Splits each access between block RAM and a small memory-mapped I/O register file at IO_BASE.
- Muxes read data back to the CPU with the same 1-cycle latency as the RAM.
- Provides an LED output register, a synchronized switch input, a byte TX FIFO with valid/ready egress, and a compare timer.

Parameters:
- WIDTH, 16, CPU data/address width
- IO_BASE, 16'hCFFD, first address of the I/O window; the window is IO_BASE..IO_BASE+7
- LED_WIDTH, 10, LED register bits used
- SW_WIDTH, 10, switch input bits
- FIFO_DEPTH, 4, TX FIFO entries, power of two

Ports:
- clk  input  1  system clock, single domain
- reset  input  1  synchronous, active-high reset
- cpu_adr  input  WIDTH  CPU address
- cpu_wdata  input  WIDTH  CPU write data
- cpu_we  input  1  CPU write enable
- cpu_rdata  output  WIDTH  read data to CPU, valid the cycle after cpu_adr
- ram_we  output  1  write enable to block RAM
- ram_rdata  input  WIDTH  block RAM read data, 1-cycle latency
- sw_in  input  SW_WIDTH  asynchronous switches
- led_out  output  LED_WIDTH  LED register
- tx_data  output  8  FIFO head byte
- tx_valid  output  1  FIFO not empty
- tx_ready  input  1  consumer accepts the head byte when tx_valid & tx_ready
- irq  output  1  timer interrupt request

Behaviour:
- Decode:
  - io_hit = (cpu_adr >= IO_BASE) && (cpu_adr <= IO_BASE+7).
  - ram_we = cpu_we & ~io_hit, combinational.
  - I/O writes never reach RAM.
- Read path:
  - io_hit is registered to sel_q, and the I/O read value is registered to io_rdata_q.
  - cpu_rdata = sel_q ? io_rdata_q : ram_rdata.
  - Latency is exactly 1 cycle for both paths.
- Register map (offset from IO_BASE):
  - +0 LED: RW; read returns zero-extended led_out.
  - +1 SW: RO; value passes through a 2-flop synchronizer, so the change is visible 2 cycles after sw_in changes.
  - +2 TXDATA: WO; a write pushes cpu_wdata[7:0]; reads return 0.
  - +3 STATUS: bit0 empty, bit1 full, bit2 timer_flag, bit3 overflow, bits[6:4] count; other bits 0. Any write clears overflow.
  - +4 TIMER_CMP: RW.
  - +5 TIMER_CNT: RO; any write clears timer_flag.
  - +6, +7: reserved; read 0, writes ignored.
- FIFO:
  - Circular buffer with wrapping read and write pointers and a count register (0..FIFO_DEPTH).
  - Pop when tx_valid & tx_ready. tx_data is the head entry; it is undefined-but-stable while empty, and tx_valid=0 while empty.
  - A push is accepted when count<FIFO_DEPTH, or when a pop happens in the same cycle. Simultaneous push and pop leaves count unchanged.
  - A push that is not accepted is dropped and sets the sticky overflow bit. Overflow is not cleared by a pop.
  - Pushed data appears on tx_data the cycle after the push if the FIFO was empty.
- Timer (see IRQ_EN):
  - TIMER_CMP=0 holds the counter at 0.
  - Otherwise the counter increments every cycle. When cnt==cmp, then cnt←0 and timer_flag←1 on the same edge.
  - Writing a new TIMER_CMP also resets cnt to 0.
  - A write to TIMER_CNT that coincides with a compare match leaves timer_flag=1; set wins.
- Reset:
  - On reset, the following are 0: led_out, pointers, count, overflow, cnt, cmp, timer_flag, synchronizer flops, sel_q, io_rdata_q.
  - Resulting outputs: tx_valid=0, irq=0. cpu_rdata follows ram_rdata the cycle after reset.
  - Reset asserted mid-burst empties the FIFO and drops in-flight bytes. A pending handshake in that cycle is not a pop.

Optional Feature:
- Macro: MMIO_TIMER_IRQ_EN.
- Defined: timer, TIMER_CMP/TIMER_CNT, and STATUS bit2 are implemented; irq = timer_flag, registered.
- Undefined: no timer logic; offsets +4/+5 read 0 and writes are ignored; STATUS bit2 = 0; irq tied 0.

Decomposition:
- Package mmio_pkg holds:
  - register offset constants: OFS_LED=0, OFS_SW=1, OFS_TX=2, OFS_STAT=3, OFS_CMP=4, OFS_CNT=5
  - STATUS bit indices
  - IO_WINDOW=8
- One sub-module, mmio_tx_fifo: parameterized depth/width FIFO with push, pop, full, empty, count, and accept outputs. The bridge holds decode, registers, synchronizer, and timer.

Test Plan:
- Write 16'h1234 to 16'h0100, then read 16'h0100: ram_we=1 on the write; cpu_rdata=ram_rdata the next cycle, and the bridge never asserts ram_we for I/O addresses.
- Write 16'h03FF to IO_BASE+0, then read it back: led_out=10'h3FF; cpu_rdata=16'h03FF one cycle later.
- With tx_ready=0, push 0xA1..0xA5:
  - STATUS reads full=1, count=4, overflow=1.
  - Raise tx_ready: bytes emerge A1,A2,A3,A4, then tx_valid=0.
- FIFO at 4 entries with tx_ready=1 and a simultaneous push of 0xB0: the push is accepted, count stays 4, overflow stays 0.
- sw_in=10'h155 applied at cycle t: SW reads 16'h0155 from address issue at t+2 onward, never earlier.
- MMIO_TIMER_IRQ_EN defined, TIMER_CMP=3:
  - irq rises 4 cycles after the write.
  - A write to TIMER_CNT clears irq.
  - With the macro undefined, irq stays 0 and +4 reads 0.

Source files
------------

// File: rtl/mmio_pkg.sv
// Shared constants for the MMIO bus bridge: register offsets inside the I/O window
// and bit positions of the STATUS register.
package mmio_pkg;

  localparam int IO_WINDOW = 8;

  localparam logic [2:0] OFS_LED  = 3'd0;
  localparam logic [2:0] OFS_SW   = 3'd1;
  localparam logic [2:0] OFS_TX   = 3'd2;
  localparam logic [2:0] OFS_STAT = 3'd3;
  localparam logic [2:0] OFS_CMP  = 3'd4;
  localparam logic [2:0] OFS_CNT  = 3'd5;

  localparam int STAT_EMPTY   = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_TFLAG   = 2;
  localparam int STAT_OVF     = 3;
  localparam int STAT_CNT_LSB = 4;
  localparam int STAT_CNT_W   = 3;

endpackage

// File: rtl/mmio_tx_fifo.sv
// Circular-buffer byte FIFO for the bridge's TX egress; DEPTH must be a power of two
// so the pointers wrap for free.
module mmio_tx_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  output logic             o_full,
  output logic [CW-1:0]    o_count,
  output logic             o_accept
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wrPtr;
  logic [AW-1:0]    r_rdPtr;
  logic [CW-1:0]    r_count;
  logic             w_pop;

  assign o_empty  = (r_count == '0);
  assign o_full   = (r_count == CW'(DEPTH));
  assign o_count  = r_count;
  assign o_data   = r_mem[r_rdPtr];
  assign w_pop    = i_pop & ~o_empty;
  // A pop in the same cycle frees the slot the push needs, so a full FIFO still accepts.
  assign o_accept = i_push & (~o_full | w_pop);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (o_accept) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)    r_rdPtr <= r_rdPtr + AW'(1);
      if (o_accept && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !o_accept) r_count <= r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (o_accept) r_mem[r_wrPtr] <= i_data;
  end

endmodule

// File: rtl/mmio_bus_bridge.sv
// Splits CPU accesses between block RAM and an 8-register I/O window (LED, switches,
// TX FIFO, status, timer). Define MMIO_TIMER_IRQ_EN to build the compare timer and irq.
module mmio_bus_bridge
  import mmio_pkg::*;
#(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] IO_BASE    = 16'hCFFD,
  parameter int               LED_WIDTH  = 10,
  parameter int               SW_WIDTH   = 10,
  parameter int               FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     cpu_adr,
  input  logic [WIDTH-1:0]     cpu_wdata,
  input  logic                 cpu_we,
  output logic [WIDTH-1:0]     cpu_rdata,
  output logic                 ram_we,
  input  logic [WIDTH-1:0]     ram_rdata,
  input  logic [SW_WIDTH-1:0]  sw_in,
  output logic [LED_WIDTH-1:0] led_out,
  output logic [7:0]           tx_data,
  output logic                 tx_valid,
  input  logic                 tx_ready,
  output logic                 irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [WIDTH:0] IO_FIRST = {1'b0, IO_BASE};
  localparam logic [WIDTH:0] IO_LAST  = IO_FIRST + (WIDTH+1)'(IO_WINDOW - 1);

  logic                 w_ioHit;
  logic [2:0]           w_ofs;
  logic                 w_ioWe;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_accept;
  logic                 w_empty;
  logic                 w_full;
  logic [CW-1:0]        w_count;
  logic                 w_tflag;
  logic [WIDTH-1:0]     w_ioRdata;
  logic                 r_sel;
  logic [WIDTH-1:0]     r_ioRdata;
  logic [LED_WIDTH-1:0] r_led;
  logic [SW_WIDTH-1:0]  r_sw1;
  logic [SW_WIDTH-1:0]  r_sw2;
  logic                 r_ovf;

  // Extra top bit keeps the window compare correct even if IO_BASE sits near the top.
  assign w_ioHit = ({1'b0, cpu_adr} >= IO_FIRST) && ({1'b0, cpu_adr} <= IO_LAST);
  assign w_ofs   = cpu_adr[2:0] - IO_BASE[2:0];
  assign w_ioWe  = cpu_we & w_ioHit;
  assign ram_we  = cpu_we & ~w_ioHit;

  assign w_push   = w_ioWe && (w_ofs == OFS_TX);
  assign w_pop    = tx_valid & tx_ready;
  assign tx_valid = ~w_empty;
  assign led_out  = r_led;

  mmio_tx_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_txFifo (
    .clk      (clk),
    .reset    (reset),
    .i_push   (w_push),
    .i_data   (cpu_wdata[7:0]),
    .i_pop    (w_pop),
    .o_data   (tx_data),
    .o_empty  (w_empty),
    .o_full   (w_full),
    .o_count  (w_count),
    .o_accept (w_accept)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_led <= '0;
      r_sw1 <= '0;
      r_sw2 <= '0;
      r_ovf <= 1'b0;
    end else begin
      r_sw1 <= sw_in;
      r_sw2 <= r_sw1;
      if (w_ioWe && (w_ofs == OFS_LED)) r_led <= cpu_wdata[LED_WIDTH-1:0];
      if (w_ioWe && (w_ofs == OFS_STAT)) r_ovf <= 1'b0;
      else if (w_push && !w_accept)      r_ovf <= 1'b1;
    end
  end

`ifdef MMIO_TIMER_IRQ_EN
  logic [WIDTH-1:0] r_cmp;
  logic [WIDTH-1:0] r_cnt;
  logic             r_tflag;
  logic             w_match;

  assign w_match = (r_cmp != '0) && (r_cnt == r_cmp);
  assign w_tflag = r_tflag;
  assign irq     = r_tflag;

  // A compare match sets the flag even when TIMER_CNT is written in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cmp   <= '0;
      r_cnt   <= '0;
      r_tflag <= 1'b0;
    end else begin
      if (w_ioWe && (w_ofs == OFS_CMP)) begin
        r_cmp <= cpu_wdata;
        r_cnt <= '0;
      end else if (r_cmp == '0 || w_match) begin
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + WIDTH'(1);
      end
      if (w_match)                           r_tflag <= 1'b1;
      else if (w_ioWe && (w_ofs == OFS_CNT)) r_tflag <= 1'b0;
    end
  end
`else
  assign w_tflag = 1'b0;
  assign irq     = 1'b0;
`endif

  always_comb begin
    w_ioRdata = '0;
    case (w_ofs)
      OFS_LED: w_ioRdata[LED_WIDTH-1:0] = r_led;
      OFS_SW:  w_ioRdata[SW_WIDTH-1:0]  = r_sw2;
      OFS_STAT: begin
        w_ioRdata[STAT_EMPTY] = w_empty;
        w_ioRdata[STAT_FULL]  = w_full;
        w_ioRdata[STAT_TFLAG] = w_tflag;
        w_ioRdata[STAT_OVF]   = r_ovf;
        w_ioRdata[STAT_CNT_LSB +: STAT_CNT_W] = STAT_CNT_W'(w_count);
      end
`ifdef MMIO_TIMER_IRQ_EN
      OFS_CMP: w_ioRdata = r_cmp;
      OFS_CNT: w_ioRdata = r_cnt;
`endif
      default: w_ioRdata = '0;
    endcase
  end

  // I/O reads are registered so they line up with the RAM's 1-cycle read latency.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sel     <= 1'b0;
      r_ioRdata <= '0;
    end else begin
      r_sel     <= w_ioHit;
      r_ioRdata <= w_ioRdata;
    end
  end

  assign cpu_rdata = r_sel ? r_ioRdata : ram_rdata;

endmodule
